dmem_dumper: RTL and testbench

DMEM_DUMPER -- requirements
Module: dmem_dumper

---
 rtl/dmem_dumper_if.sv | 26 ++
 rtl/dmem_dumper.sv | 190 +++++++++++++++++++
 tb/tb_dmem_dumper.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_dumper_if.sv
// Bus bundle for dmem_dumper: dump request/status, BRAM debug read port and byte stream.
interface dmem_dumper_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int CNT_WIDTH  = 9
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [CNT_WIDTH-1:0]  word_cnt;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] dbg_addr;
    logic [31:0]           dbg_data;
    logic [7:0]            tx_data;
    logic                  tx_valid;
    logic                  tx_ready;

    modport master (
        input  start, base_addr, word_cnt, dbg_data, tx_ready,
        output busy, done, dbg_addr, tx_data, tx_valid
    );

    modport slave (
        output start, base_addr, word_cnt, dbg_data, tx_ready,
        input  busy, done, dbg_addr, tx_data, tx_valid
    );
endinterface

// File: rtl/dmem_dumper.sv
// Streams a range of data-BRAM words out as little-endian bytes on a valid/ready port.
// Optional trailing XOR checksum byte is enabled by defining DUMP_CHECKSUM_EN.
module dmem_dumper #(
    parameter int ADDR_WIDTH = 10,
    parameter int CNT_WIDTH  = 9
) (
    input  logic          clk,
    input  logic          rst,
    dmem_dumper_if.master bus
);

`ifdef DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        LATCH = 3'd2,
        SEND  = 3'd3,
        CSUM  = 3'd4,
        FIN   = 3'd5
    } state_t;
    localparam state_t END_STATE = CSUM;

    function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] data);
        csum_update = acc ^ data;
    endfunction
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        LATCH = 3'd2,
        SEND  = 3'd3,
        FIN   = 3'd5
    } state_t;
    localparam state_t END_STATE = FIN;
`endif

    localparam logic [ADDR_WIDTH-1:0] WORD_STRIDE = ADDR_WIDTH'(3'd4);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE     = CNT_WIDTH'(1'b1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ZERO    = CNT_WIDTH'(1'b0);

    state_t                state_r, state_next_s;
    logic [ADDR_WIDTH-1:0] dbg_addr_r, addr_next_s;
    logic [CNT_WIDTH-1:0]  cnt_r, cnt_next_s;
    logic [31:0]           shift_r, shift_next_s;
    logic [1:0]            idx_r, idx_next_s;
    logic [7:0]            tx_data_r, data_next_s;
    logic                  tx_valid_r, valid_next_s;
    logic                  busy_r;
    logic                  done_r;
    logic                  xfer_s;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]            csum_r, csum_next_s;
`endif

    // Byte addresses are word aligned, so the two low base bits are dropped.
    logic unused_base_bits_s;
    assign unused_base_bits_s = &{1'b0, bus.base_addr[1:0]};

    assign xfer_s = tx_valid_r & bus.tx_ready;

    // State register and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            dbg_addr_r <= '0;
            cnt_r      <= '0;
            shift_r    <= 32'h0000_0000;
            idx_r      <= 2'd0;
            tx_data_r  <= 8'h00;
            tx_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            csum_r     <= 8'h00;
`endif
        end else begin
            state_r    <= state_next_s;
            dbg_addr_r <= addr_next_s;
            cnt_r      <= cnt_next_s;
            shift_r    <= shift_next_s;
            idx_r      <= idx_next_s;
            tx_data_r  <= data_next_s;
            tx_valid_r <= valid_next_s;
            busy_r     <= (state_next_s != IDLE);
            done_r     <= (state_next_s == FIN);
`ifdef DUMP_CHECKSUM_EN
            csum_r     <= csum_next_s;
`endif
        end
    end

    // Next-state and next-output logic for the dump sequencer.
    always_comb begin
        state_next_s = state_r;
        addr_next_s  = dbg_addr_r;
        cnt_next_s   = cnt_r;
        shift_next_s = shift_r;
        idx_next_s   = idx_r;
        data_next_s  = tx_data_r;
        valid_next_s = 1'b0;
`ifdef DUMP_CHECKSUM_EN
        csum_next_s  = csum_r;
`endif
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    addr_next_s = {bus.base_addr[ADDR_WIDTH-1:2], 2'b00};
                    cnt_next_s  = bus.word_cnt;
`ifdef DUMP_CHECKSUM_EN
                    csum_next_s = 8'h00;
`endif
                    if (bus.word_cnt == CNT_ZERO) begin
                        state_next_s = END_STATE;
`ifdef DUMP_CHECKSUM_EN
                        valid_next_s = 1'b1;
                        data_next_s  = 8'h00;
`endif
                    end else begin
                        state_next_s = ADDR;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            ADDR: begin
                state_next_s = LATCH;
            end
            LATCH: begin
                shift_next_s = bus.dbg_data;
                idx_next_s   = 2'd0;
                data_next_s  = bus.dbg_data[7:0];
                valid_next_s = 1'b1;
                state_next_s = SEND;
            end
            SEND: begin
                valid_next_s = 1'b1;
                if (xfer_s) begin
`ifdef DUMP_CHECKSUM_EN
                    csum_next_s = csum_update(csum_r, tx_data_r);
`endif
                    if (idx_r == 2'd3) begin
                        addr_next_s  = dbg_addr_r + WORD_STRIDE;
                        cnt_next_s   = cnt_r - CNT_ONE;
                        valid_next_s = 1'b0;
                        if (cnt_r != CNT_ONE) begin
                            state_next_s = ADDR;
                        end else begin
                            state_next_s = END_STATE;
`ifdef DUMP_CHECKSUM_EN
                            valid_next_s = 1'b1;
                            data_next_s  = csum_update(csum_r, tx_data_r);
`endif
                        end
                    end else begin
                        // Rotate rather than shift so the next byte always sits in [15:8].
                        idx_next_s   = idx_r + 2'd1;
                        shift_next_s = {shift_r[7:0], shift_r[31:8]};
                        data_next_s  = shift_r[15:8];
                    end
                end else begin
                    state_next_s = SEND;
                end
            end
`ifdef DUMP_CHECKSUM_EN
            CSUM: begin
                valid_next_s = 1'b1;
                if (xfer_s) begin
                    valid_next_s = 1'b0;
                    state_next_s = FIN;
                end else begin
                    state_next_s = CSUM;
                end
            end
`endif
            FIN: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.dbg_addr = dbg_addr_r;
    assign bus.tx_data  = tx_data_r;
    assign bus.tx_valid = tx_valid_r;

endmodule

// File: tb/tb_dmem_dumper.sv
// Directed bench for dmem_dumper: expected bytes are queued from a BRAM model and popped on each transfer.
module tb_dmem_dumper;
    localparam int AW = 10;
    localparam int CW = 9;
`ifdef DUMP_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_dumper_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus_if ();

    dmem_dumper #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    logic [31:0] mem [0:255];
    assign bus_if.dbg_data = mem[bus_if.dbg_addr[9:2]];

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q [$];
    logic [7:0]  last_byte;
    logic [9:0]  addr_log [$];
    int          byte_count = 0;
    int          done_count = 0;
    bit          zero_mode = 1'b0;
    logic        stall_prev = 1'b0;
    logic [7:0]  stall_data = 8'h00;
    logic        prev_valid = 1'b0;
    int          low_run = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_dump(input logic [9:0] base, input int n);
        logic [9:0]  a;
        logic [31:0] w;
        logic [7:0]  cs;
        a  = {base[9:2], 2'b00};
        cs = 8'h00;
        for (int i = 0; i < n; i++) begin
            w = mem[a[9:2]];
            for (int b = 0; b < 4; b++) begin
                exp_q.push_back(w[8*b +: 8]);
                cs        = cs ^ w[8*b +: 8];
                last_byte = w[8*b +: 8];
            end
            a = a + 10'd4;
        end
        if (CS != 0) begin
            exp_q.push_back(cs);
            last_byte = cs;
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that sampled start.
    task automatic do_start(input logic [9:0] base, input logic [8:0] cnt);
        bus_if.base_addr = base;
        bus_if.word_cnt  = cnt;
        bus_if.start     = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit toggle, output int cyc);
        cyc = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (bus_if.done) begin
                cyc = i;
                break;
            end
            @(posedge clk);
            #1;
            if (toggle) bus_if.tx_ready = ~bus_if.tx_ready;
        end
        check("done_within_budget", 32'(cyc != 0), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Transfer monitor: scoreboard pops, stall stability, inter-word gap, done and address log.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
            prev_valid = 1'b0;
            low_run    = 0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", 32'(bus_if.tx_valid), 32'd1);
                check("stall_data", 32'(bus_if.tx_data), 32'(stall_data));
            end
            if (bus_if.tx_valid && !prev_valid && !zero_mode)
                check("valid_gap", 32'(low_run), 32'd2);
            if (!bus_if.busy || bus_if.tx_valid) low_run = 0;
            else low_run++;
            if (bus_if.tx_valid && bus_if.tx_ready) begin
                check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("tx_byte", 32'(bus_if.tx_data), 32'(exp_q.pop_front()));
                byte_count++;
            end
            if (bus_if.done) done_count++;
            if (bus_if.busy && (addr_log.size() == 0 || addr_log[$] != bus_if.dbg_addr))
                addr_log.push_back(bus_if.dbg_addr);
            stall_prev = bus_if.tx_valid && !bus_if.tx_ready;
            stall_data = bus_if.tx_data;
            prev_valid = bus_if.tx_valid;
        end
    end

    initial begin
        int         cyc;
        int         k;
        logic [9:0] held_addr;

        rst              = 1'b1;
        bus_if.start     = 1'b0;
        bus_if.base_addr = 10'h000;
        bus_if.word_cnt  = 9'd0;
        bus_if.tx_ready  = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 32'hA5C3_0000 | 32'(i * 7 + 1);
        mem[0] = 32'h0000_0001;
        mem[1] = 32'h0000_0003;
        mem[2] = 32'h0000_0005;
        mem[255] = 32'hDEAD_BEEF;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus_if.busy), 32'd0);
        check("rst_done", 32'(bus_if.done), 32'd0);
        check("rst_valid", 32'(bus_if.tx_valid), 32'd0);
        check("rst_tx_data", 32'(bus_if.tx_data), 32'h00);
        check("rst_dbg_addr", 32'(bus_if.dbg_addr), 32'h000);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic dump; inputs scrambled after capture must not matter.
        byte_count = 0; done_count = 0;
        bus_if.tx_ready = 1'b1;
        push_dump(10'h000, 3);
        do_start(10'h000, 9'd3);
        bus_if.base_addr = 10'h155;
        bus_if.word_cnt  = 9'd7;
        check("busy_after_start", 32'(bus_if.busy), 32'd1);
        wait_done(80, 1'b0, cyc);
        check("s1_queue_empty", 32'(exp_q.size()), 32'd0);
        check("s1_bytes", 32'(byte_count), 32'(12 + CS));
        check("s1_done_count", 32'(done_count), 32'd1);
        check("s1_busy_low", 32'(bus_if.busy), 32'd0);
        check("idle_valid_low", 32'(bus_if.tx_valid), 32'd0);
        check("idle_tx_data_held", 32'(bus_if.tx_data), 32'(last_byte));
        held_addr = bus_if.dbg_addr;
        repeat (3) @(posedge clk);
        #1;
        check("idle_dbg_addr_held", 32'(bus_if.dbg_addr), 32'(held_addr));

        // Same dump with tx_ready toggling each cycle.
        byte_count = 0; done_count = 0;
        push_dump(10'h000, 3);
        do_start(10'h000, 9'd3);
        wait_done(150, 1'b1, cyc);
        bus_if.tx_ready = 1'b1;
        check("s2_queue_empty", 32'(exp_q.size()), 32'd0);
        check("s2_bytes", 32'(byte_count), 32'(12 + CS));
        check("s2_done_count", 32'(done_count), 32'd1);
        check("s2_busy_low", 32'(bus_if.busy), 32'd0);

        // Address wrap from the top of the debug address space.
        byte_count = 0; done_count = 0;
        addr_log.delete();
        push_dump(10'h3FD, 2);
        do_start(10'h3FD, 9'd2);
        wait_done(80, 1'b0, cyc);
        check("wrap_log_len", 32'(addr_log.size() >= 2), 32'd1);
        if (addr_log.size() >= 2) begin
            check("wrap_addr0", 32'(addr_log[0]), 32'h3FC);
            check("wrap_addr1", 32'(addr_log[1]), 32'h000);
        end
        check("wrap_bytes", 32'(byte_count), 32'(8 + CS));
        check("wrap_queue_empty", 32'(exp_q.size()), 32'd0);

        // Zero-length dump.
        byte_count = 0; done_count = 0;
        zero_mode = 1'b1;
        push_dump(10'h000, 0);
        do_start(10'h020, 9'd0);
        wait_done(10, 1'b0, cyc);
        zero_mode = 1'b0;
        check("zero_done_latency", 32'(cyc >= 1 && cyc <= 3), 32'd1);
        check("zero_bytes", 32'(byte_count), 32'(CS));
        check("zero_done_count", 32'(done_count), 32'd1);
        check("zero_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset while the second byte is stalled.
        bus_if.tx_ready = 1'b0;
        push_dump(10'h000, 3);
        do_start(10'h000, 9'd3);
        for (k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus_if.tx_valid) break;
        end
        check("pre_rst_valid", 32'(bus_if.tx_valid), 32'd1);
        @(posedge clk);
        #1;
        bus_if.tx_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_if.tx_ready = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(bus_if.tx_valid), 32'd0);
        check("async_rst_busy", 32'(bus_if.busy), 32'd0);
        check("async_rst_dbg_addr", 32'(bus_if.dbg_addr), 32'h000);
        check("async_rst_tx_data", 32'(bus_if.tx_data), 32'h00);
        exp_q.delete();
        @(posedge clk);
        #1;
        push_dump(10'h000, 3);
        bus_if.tx_ready  = 1'b1;
        bus_if.base_addr = 10'h000;
        bus_if.word_cnt  = 9'd3;
        bus_if.start     = 1'b1;
        rst = 1'b0;
        byte_count = 0; done_count = 0;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        check("post_rst_start_busy", 32'(bus_if.busy), 32'd1);
        wait_done(80, 1'b0, cyc);
        check("post_rst_bytes", 32'(byte_count), 32'(12 + CS));
        check("post_rst_queue_empty", 32'(exp_q.size()), 32'd0);
        check("post_rst_done_count", 32'(done_count), 32'd1);

        // A second start while busy is dropped.
        byte_count = 0; done_count = 0;
        push_dump(10'h010, 2);
        do_start(10'h010, 9'd2);
        repeat (3) @(posedge clk);
        #1;
        do_start(10'h000, 9'd5);
        wait_done(80, 1'b0, cyc);
        repeat (12) @(posedge clk);
        #1;
        check("busy_start_done_count", 32'(done_count), 32'd1);
        check("busy_start_bytes", 32'(byte_count), 32'(8 + CS));
        check("busy_start_queue_empty", 32'(exp_q.size()), 32'd0);
        check("busy_start_idle", 32'(bus_if.busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
